// File: rtl/axis_branch_fifo_if.sv
// AXI-Stream handshake bundle (tdata/tvalid/tready) for one stream link.
// master drives tdata/tvalid and receives tready; slave is the reverse.
interface axis_branch_fifo_if #(
   parameter int W = 32
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_branch_fifo.sv
// Per-branch FWFT elastic buffer behind an AXIS splitter copy port, with
// a saturating count of samples offered while full.
// Ports: clk, rst (async, active-high); s_axis (slave stream in);
// m_axis (master stream out); fill_level (0..DEPTH occupancy);
// ovf_count / ovf_flag (loss counter and sticky flag); ovf_clr (sync clear).
module axis_branch_fifo #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int ADDR_WIDTH       = 4,
   parameter int OVF_WIDTH        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   axis_branch_fifo_if.slave     s_axis,
   axis_branch_fifo_if.master    m_axis,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic [OVF_WIDTH-1:0]  ovf_count,
   output logic                  ovf_flag,
   input  logic                  ovf_clr
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

   logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0]       wr_ptr;
   logic [ADDR_WIDTH-1:0]       rd_ptr;
   logic                        wr_en;
   logic                        rd_en;
   logic                        blocked;

   // tready is gated by rst so it drops the moment reset asserts.
   assign s_axis.tready = !rst && (fill_level != FULL);
   assign m_axis.tvalid = (fill_level != '0);
   assign m_axis.tdata  = mem[rd_ptr];

   assign wr_en   = s_axis.tvalid && s_axis.tready;
   assign rd_en   = m_axis.tvalid && m_axis.tready;
   assign blocked = s_axis.tvalid && !s_axis.tready;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= s_axis.tdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         ovf_count  <= '0;
         ovf_flag   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (wr_en && !rd_en) begin
            fill_level <= fill_level + (ADDR_WIDTH + 1)'(1);
         end else if (rd_en && !wr_en) begin
            fill_level <= fill_level - (ADDR_WIDTH + 1)'(1);
         end
         // Clear takes priority over an increment on the same edge.
         if (ovf_clr) begin
            ovf_count <= '0;
            ovf_flag  <= 1'b0;
         end else if (blocked) begin
            ovf_flag <= 1'b1;
            if (ovf_count != '1) begin
               ovf_count <= ovf_count + OVF_WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: doc/axis_branch_fifo.md
Name: axis_branch_fifo

Overview:
- Per-branch elastic buffer placed directly downstream of each copy output of the AXIS splitter.
- The splitter ORs the branch tready signals, so one stalled consumer can miss samples. This block absorbs short stalls locally.
- It counts every sample offered while full, so firmware can detect branch data loss.
- Synchronous FIFO, first-word-fall-through output, single clock domain.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of tdata on both sides.
- ADDR_WIDTH, 4, log2 of FIFO depth. DEPTH = 2^ADDR_WIDTH = 16. Legal range 1..10.
- OVF_WIDTH, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- S_AXIS_DATA_tdata  in  AXIS_TDATA_WIDTH  input sample (from a splitter copy port).
- S_AXIS_DATA_tvalid  in  1  input valid.
- S_AXIS_DATA_tready  out  1  input ready; high when not full and not in reset.
- M_AXIS_DATA_tdata  out  AXIS_TDATA_WIDTH  head-of-FIFO sample.
- M_AXIS_DATA_tvalid  out  1  FIFO not empty.
- M_AXIS_DATA_tready  in  1  downstream ready.
- fill_level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- ovf_count  out  OVF_WIDTH  samples offered while full; saturating.
- ovf_flag  out  1  sticky; set on first overflow.
- ovf_clr  in  1  synchronous single-cycle clear of ovf_count and ovf_flag.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values (applied immediately on rst rising, held while rst high):
  - write pointer 0, read pointer 0, fill_level 0.
  - M_AXIS_DATA_tvalid 0, S_AXIS_DATA_tready 0.
  - ovf_count 0, ovf_flag 0.
  - Memory contents are not reset.
- After rst deasserts: S_AXIS_DATA_tready rises combinationally (empty FIFO).
- Write: on a clk edge with S tvalid && S tready, store tdata at wr_ptr and increment wr_ptr (wraps modulo DEPTH).
- Read: on a clk edge with M tvalid && M tready, increment rd_ptr (wraps modulo DEPTH).
- M_AXIS_DATA_tdata = mem[rd_ptr], read asynchronously. Valid whenever M tvalid = 1; don't-care otherwise.
- Latency: a sample accepted at edge N appears on M with tvalid = 1 after edge N (1 cycle). No same-cycle bypass when empty.
- fill_level update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- M_AXIS_DATA_tvalid = (fill_level != 0). S_AXIS_DATA_tready = !rst && (fill_level != DEPTH).
- Full with simultaneous read: tready stays 0 that cycle; the read frees a slot and tready rises next cycle. No write-through when full.
- Empty with simultaneous offer: the write is accepted; no read occurs (tvalid was 0).
- Once S tvalid is asserted, tvalid/tdata must not depend on tready.
- M tvalid/tdata are stable while M tready is low (FWFT head does not change without a read).
- Overflow:
  - Each edge with S tvalid = 1 and S tready = 0 (outside reset) increments ovf_count, saturating at all ones, and sets ovf_flag.
  - Stalled upstream repeat cycles count individually. A stalled splitter branch counts each cycle its sample is not taken.
  - ovf_clr = 1 on an edge forces ovf_count to 0 and ovf_flag to 0. Clear wins over a same-edge increment.
- Reset mid-operation discards all contents; M tvalid drops asynchronously.
- No tlast or tuser; no packet semantics.

Test Plan:
- Reset then write 0x00000001..0x00000005 back-to-back with M tready = 1:
  - M tvalid first high one cycle after the first write.
  - Outputs 1..5 in order; fill_level never exceeds 1.
  - ovf_count = 0.
- Hold M tready = 0 and offer 20 consecutive samples 0x100..0x113 with tvalid held high:
  - 16 accepted (0x100..0x10F); tready drops after the 16th; fill_level = 16.
  - ovf_count increments each cycle while blocked; 4 cycles of offering 0x110 → ovf_count = 4, ovf_flag = 1.
- From full, assert M tready for one cycle with S tvalid high:
  - Read of 0x100 occurs; no write that cycle; fill_level = 15.
  - Next cycle tready = 1 and 0x110 is written; fill_level = 16.
- Continuous simultaneous read/write at fill_level = 8 for 40 cycles:
  - fill_level holds 8; pointers wrap at least twice.
  - Output sequence matches input order exactly.
- Drive ovf_count to 0xFFFF (OVF_WIDTH = 16), then continue blocking: count stays 0xFFFF. Pulse ovf_clr in the same cycle as a blocked offer → ovf_count = 0, ovf_flag = 0.
- Assert rst asynchronously mid-clock at fill_level = 9:
  - M tvalid, S tready and fill_level go to 0 before the next edge.
  - After release, first sample written is first sample read.
